// File: rtl/ps_ddr_pkg.sv
// Shared definitions for the PS-DDR write packer: FSM state encoding,
// default ring base address and a constant-evaluable clog2 helper.
package ps_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3E00_0000;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ps_ddr_wr_pack_if.sv
// Bus bundle between the sample source / S2MM write stage and the packer.
// master = the packer itself, slave = the surrounding source and write stage.
interface ps_ddr_wr_pack_if;

    logic        enable;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_ready;
    logic        ps_ddr_wr_en;
    logic [31:0] ps_ddr_wr_data;
    logic        ps_ddr_wr_start;
    logic [31:0] ps_ddr_wr_addr;
    logic [31:0] ps_ddr_wr_length;
    logic        wr_done;
    logic        pkt_irq;
    logic [7:0]  pkt_slot;
    logic        overflow;

    modport master (
        input  enable, src_valid, src_data, wr_done,
        output src_ready, ps_ddr_wr_en, ps_ddr_wr_data, ps_ddr_wr_start,
               ps_ddr_wr_addr, ps_ddr_wr_length, pkt_irq, pkt_slot, overflow
    );

    modport slave (
        output enable, src_valid, src_data, wr_done,
        input  src_ready, ps_ddr_wr_en, ps_ddr_wr_data, ps_ddr_wr_start,
               ps_ddr_wr_addr, ps_ddr_wr_length, pkt_irq, pkt_slot, overflow
    );

endinterface

// File: rtl/ps_ddr_ring_addr.sv
// Ring slot counter and per-packet DDR byte address.
// load_i latches the address of the current slot; advance_i steps to the
// next slot, wrapping to slot 0 after the last one.
module ps_ddr_ring_addr
    import ps_ddr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int          PKT_WORDS = 80,
    parameter int          RING_PKTS = 16,
    parameter int          SLOT_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic              load_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic [31:0]       addr_o
);

    localparam logic [31:0]       PKT_BYTES = 32'(PKT_WORDS * 4);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RING_PKTS - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [31:0]       addr_q, addr_d;

    // Next slot and next address; address math wraps modulo 2^32.
    always_comb begin
        slot_d = slot_q;
        addr_d = addr_q;
        if (advance_i) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end
        if (load_i) begin
            addr_d = BASE_ADDR + 32'(slot_q) * PKT_BYTES;
        end
    end

    // Slot and address registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= '0;
            addr_q <= BASE_ADDR;
        end else begin
            slot_q <= slot_d;
            addr_q <= addr_d;
        end
    end

    assign slot_o = slot_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/ps_ddr_wr_pack.sv
// Upstream feeder for the PS-DDR S2MM write stage: forwards accepted 32-bit
// samples into the write-stage FIFO, cuts them into fixed packets and issues
// one start pulse + ring address per packet, using the write stage's final
// beat as the completion event.
module ps_ddr_wr_pack
    import ps_ddr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
    parameter int          PKT_WORDS  = 80,
    parameter int          RING_PKTS  = 16,
    parameter int          START_HOLD = 4,
    parameter int          MAX_PEND   = 2
) (
    input  logic             clk_ps,
    input  logic             rst,
    ps_ddr_wr_pack_if.master bus
);

    localparam int WORD_W = (clog2(PKT_WORDS) < 1) ? 1 : clog2(PKT_WORDS);
    localparam int PEND_W = (clog2(MAX_PEND + 1) < 1) ? 1 : clog2(MAX_PEND + 1);
    localparam int HOLD_W = (clog2(START_HOLD) < 1) ? 1 : clog2(START_HOLD);
    localparam int SLOT_W = (clog2(RING_PKTS) < 1) ? 1 : clog2(RING_PKTS);

    localparam logic [31:0]       PKT_BYTES = 32'(PKT_WORDS * 4);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(PKT_WORDS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_START     = START;
    localparam logic [1:0] S_WAIT_DONE = WAIT_DONE;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] word_cnt_q;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              wr_en_q;
    logic [31:0]       wr_data_q;
    logic              pkt_irq_q;
    logic [7:0]        pkt_slot_q;
    logic              overflow_q;

    logic              src_ready;
    logic              accept;
    logic              pkt_done;
    logic              issue;
    logic              complete;
    logic [SLOT_W-1:0] slot;
    logic [31:0]       addr;

    assign src_ready = bus.enable & (pend_q < PEND_MAX);
    assign accept    = bus.src_valid & src_ready;
    assign pkt_done  = accept & (word_cnt_q == WORD_LAST);
    assign issue     = (state_q == S_IDLE) & (pend_q != '0);
    assign complete  = (state_q == S_WAIT_DONE) & bus.wr_done;

    // Register each accepted word toward the write-stage FIFO, one cycle late.
    always_ff @(posedge clk_ps) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            // NOTE: the data path is reset only because its output is defined
            // as zero after reset; wr_en_q alone qualifies it otherwise.
            wr_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= bus.src_data;
            end
        end
    end

    // Count accepted words within the current packet; holds while stalled.
    always_ff @(posedge clk_ps) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (accept) begin
            word_cnt_q <= (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + 1'b1;
        end
    end

    // Pending packets: +1 per finished packet, -1 per issue, net 0 when both.
    always_comb begin
        // NOTE: default first so every path assigns pend_d and no latch forms.
        pend_d = pend_q;
        if (pkt_done && !issue) begin
            pend_d = pend_q + 1'b1;
        end else if (!pkt_done && issue) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // Pending counter register.
    always_ff @(posedge clk_ps) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Packet issue FSM: wait for a pending packet, hold start, wait for done.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    state_d = S_START;
                    hold_d  = '0;
                end
            end
            S_START: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.wr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and start-hold counter registers.
    always_ff @(posedge clk_ps) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Completion pulse, completed slot, and sticky overflow on stray wr_done.
    always_ff @(posedge clk_ps) begin
        if (rst) begin
            pkt_irq_q  <= 1'b0;
            pkt_slot_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            pkt_irq_q <= complete;
            if (complete) begin
                pkt_slot_q <= 8'(slot);
            end
            if (bus.wr_done && (state_q != S_WAIT_DONE)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    ps_ddr_ring_addr #(
        .BASE_ADDR (BASE_ADDR),
        .PKT_WORDS (PKT_WORDS),
        .RING_PKTS (RING_PKTS),
        .SLOT_W    (SLOT_W)
    ) u_ring_addr (
        .clk_i     (clk_ps),
        .rst_i     (rst),
        .advance_i (complete),
        .load_i    (issue),
        .slot_o    (slot),
        .addr_o    (addr)
    );

    assign bus.src_ready        = src_ready;
    assign bus.ps_ddr_wr_en     = wr_en_q;
    assign bus.ps_ddr_wr_data   = wr_data_q;
    assign bus.ps_ddr_wr_start  = (state_q == S_START);
    assign bus.ps_ddr_wr_addr   = addr;
    assign bus.ps_ddr_wr_length = PKT_BYTES;
    assign bus.pkt_irq          = pkt_irq_q;
    assign bus.pkt_slot         = pkt_slot_q;
    assign bus.overflow         = overflow_q;

endmodule
